// File: rtl/regfile_mp_if.sv
// regfile_mp_if: write port, packed read ports and status outputs of the register file
interface regfile_mp_if #(
  parameter int WIDTH      = 16,
  parameter int REG_BITS   = 5,
  parameter int READ_PORTS = 2
);
  logic                           reg_write;
  logic [REG_BITS-1:0]            write_index;
  logic [WIDTH-1:0]               write_data;
  logic [READ_PORTS*REG_BITS-1:0] read_index;
  logic [READ_PORTS*WIDTH-1:0]    read_data;
  logic                           busy;
  logic                           write_dropped;
  modport master (
    output reg_write, write_index, write_data, read_index,
    input  read_data, busy, write_dropped
  );
  modport slave (
    input  reg_write, write_index, write_data, read_index,
    output read_data, busy, write_dropped
  );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file, r0 hardwired to zero, optional
// write-to-read bypass and a post-reset zeroing sweep over entries 1..DEPTH-1.
module regfile_mp #(
  parameter int WIDTH          = 16,
  parameter int REG_BITS       = 5,
  parameter int DEPTH          = 17,
  parameter int READ_PORTS     = 2,
  parameter int BYPASS         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic           clk,
  input logic           reset_n,
  regfile_mp_if.slave   bus
);
  typedef enum logic {CLEAR, READY} state_t;
  state_t              state_q;
  logic [REG_BITS-1:0] cnt_q;
  logic                busy_q;
  logic                drop_q;
  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic                wr_ok;
  function automatic logic valid(input logic [REG_BITS-1:0] i);
    return i != '0 && 32'(i) < 32'(DEPTH);
  endfunction
  assign wr_ok = state_q == READY && bus.reg_write && valid(bus.write_index);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= CLEAR_ON_RESET != 0 ? CLEAR : READY;
      cnt_q   <= REG_BITS'(1);
      busy_q  <= CLEAR_ON_RESET != 0;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= bus.reg_write && bus.write_index != '0 && (busy_q || !valid(bus.write_index));
      if (state_q == CLEAR) begin
        cnt_q <= cnt_q + 1'b1;
        if (32'(cnt_q) == 32'(DEPTH - 1)) begin
          state_q <= READY;
          busy_q  <= 1'b0;
        end
      end
    end
  // the clear sweep owns the write port while busy; user writes are dropped then
  always_ff @(posedge clk)
    if (busy_q || wr_ok)
      mem_q[busy_q ? cnt_q : bus.write_index] <= busy_q ? '0 : bus.write_data;
  for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
    logic [REG_BITS-1:0] idx;
    assign idx = bus.read_index[p*REG_BITS +: REG_BITS];
    assign bus.read_data[p*WIDTH +: WIDTH] = (busy_q || !valid(idx)) ? '0 :
      (BYPASS != 0 && wr_ok && bus.write_index == idx) ? bus.write_data : mem_q[idx];
  end
  assign bus.busy          = busy_q;
  assign bus.write_dropped = drop_q;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: three configurations driven by shared stimulus, checked every
// cycle against an array model, plus directed literal checks.
module tb_regfile_mp;
  localparam int D = 17;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        reg_write;
  logic [4:0]  wi;
  logic [31:0] wd;
  logic [19:0] ri;
  int          errs = 0;
  int          checks = 0;
  int          clr;
  logic        dab, dc;
  logic [15:0] mab [32];
  logic [31:0] mc [32];
  logic        known [32];
  logic [4:0]  ix;
  logic [31:0] ea, eb, ec;
  int          n;
  always #5 clk = ~clk;
  regfile_mp_if #(.WIDTH(16), .REG_BITS(5), .READ_PORTS(2)) ifa ();
  regfile_mp_if #(.WIDTH(16), .REG_BITS(5), .READ_PORTS(2)) ifb ();
  regfile_mp_if #(.WIDTH(32), .REG_BITS(5), .READ_PORTS(4)) ifc ();
  assign ifa.reg_write = reg_write;
  assign ifa.write_index = wi;
  assign ifa.write_data = wd[15:0];
  assign ifa.read_index = ri[9:0];
  assign ifb.reg_write = reg_write;
  assign ifb.write_index = wi;
  assign ifb.write_data = wd[15:0];
  assign ifb.read_index = ri[9:0];
  assign ifc.reg_write = reg_write;
  assign ifc.write_index = wi;
  assign ifc.write_data = wd;
  assign ifc.read_index = ri;
  regfile_mp #(.WIDTH(16), .REG_BITS(5), .DEPTH(D), .READ_PORTS(2), .BYPASS(1), .CLEAR_ON_RESET(1))
    dut_a (.clk(clk), .reset_n(reset_n), .bus(ifa));
  regfile_mp #(.WIDTH(16), .REG_BITS(5), .DEPTH(D), .READ_PORTS(2), .BYPASS(0), .CLEAR_ON_RESET(1))
    dut_b (.clk(clk), .reset_n(reset_n), .bus(ifb));
  regfile_mp #(.WIDTH(32), .REG_BITS(5), .DEPTH(D), .READ_PORTS(4), .BYPASS(1), .CLEAR_ON_RESET(0))
    dut_c (.clk(clk), .reset_n(reset_n), .bus(ifc));
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      if (errs <= 50) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [4:0] i, input logic [31:0] d);
    reg_write = 1'b1;
    wi = i;
    wd = d;
    step();
    reg_write = 1'b0;
  endtask
  // Model: A/B contents are all zero from reset until written; busy lasts D-1 edges.
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      clr <= D - 1;
      dab <= 1'b0;
      dc  <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        mab[i]   <= '0;
        known[i] <= 1'b0;
      end
    end else begin
      dab <= reg_write && wi != 0 && (clr != 0 || wi >= D);
      dc  <= reg_write && wi >= D;
      if (reg_write && wi != 0 && wi < D) begin
        if (clr == 0) mab[wi] <= wd[15:0];
        mc[wi]    <= wd;
        known[wi] <= 1'b1;
      end
      if (clr != 0) clr <= clr - 1;
    end
  always @(negedge clk) begin
    for (int p = 0; p < 2; p++) begin
      ix = ri[p*5 +: 5];
      ea = (clr != 0 || ix == 0 || ix >= D) ? '0 :
           (reg_write && wi == ix) ? {16'h0, wd[15:0]} : {16'h0, mab[ix]};
      eb = (clr != 0 || ix == 0 || ix >= D) ? '0 : {16'h0, mab[ix]};
      chk("rd_a", 128'(ifa.read_data[p*16 +: 16]), 128'(ea));
      chk("rd_b", 128'(ifb.read_data[p*16 +: 16]), 128'(eb));
    end
    for (int p = 0; p < 4; p++) begin
      ix = ri[p*5 +: 5];
      ec = (reg_write && wi == ix) ? wd : mc[ix];
      if (ix == 0 || ix >= D) chk("rd_c_zero", 128'(ifc.read_data[p*32 +: 32]), 128'(0));
      else if (reset_n && (reg_write && wi == ix || known[ix])) chk("rd_c", 128'(ifc.read_data[p*32 +: 32]), 128'(ec));
    end
    chk("busy_a", 128'(ifa.busy), 128'(clr != 0));
    chk("busy_b", 128'(ifb.busy), 128'(clr != 0));
    chk("busy_c", 128'(ifc.busy), 128'(0));
    chk("drop_a", 128'(ifa.write_dropped), 128'(dab));
    chk("drop_b", 128'(ifb.write_dropped), 128'(dab));
    chk("drop_c", 128'(ifc.write_dropped), 128'(dc));
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    reset_n = 1'b1;
    reg_write = 1'b0;
    wi = '0;
    wd = '0;
    ri = '0;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    #2 chk("busy_c_release", 128'(ifc.busy), 128'(0));
    n = 0;
    while (ifa.busy === 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("clear_edges", 128'(n), 128'(16));
    wr(5'd5, 32'h1234);
    wr(5'd16, 32'hBEEF);
    ri = {5'd0, 5'd0, 5'd16, 5'd5};
    #2 chk("basic_a", 128'(ifa.read_data), 128'(32'hBEEF1234));
    ri = {5'd0, 5'd0, 5'd0, 5'd3};
    reg_write = 1'b1;
    wi = 5'd3;
    wd = 32'hA5A5;
    #2 chk("bypass_a", 128'(ifa.read_data[15:0]), 128'(16'hA5A5));
    chk("nobypass_b", 128'(ifb.read_data[15:0]), 128'(16'h0000));
    step();
    reg_write = 1'b0;
    #2 chk("nobypass_b_after", 128'(ifb.read_data[15:0]), 128'(16'hA5A5));
    ri = '0;
    wr(5'd0, 32'hFFFF);
    #2 chk("r0_read", 128'(ifa.read_data[15:0]), 128'(0));
    chk("r0_nodrop", 128'(ifa.write_dropped), 128'(0));
    wr(5'd20, 32'hFFFF);
    ri = {5'd0, 5'd0, 5'd0, 5'd20};
    #2 chk("r20_drop", 128'(ifa.write_dropped), 128'(1));
    chk("r20_read", 128'(ifa.read_data[15:0]), 128'(0));
    step();
    chk("r20_pulse_end", 128'(ifa.write_dropped), 128'(0));
    ri = {4{5'd1}};
    wr(5'd1, 32'hDEADBEEF);
    #2 chk("c_four_ports", 128'(ifc.read_data), {4{32'hDEADBEEF}});
    step();
    reset_n = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    repeat (2) step();
    wr(5'd7, 32'h7777);
    chk("drop_busy", 128'(ifa.write_dropped), 128'(1));
    repeat (4) step();
    reset_n = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    repeat (15) step();
    chk("busy_edge15", 128'(ifa.busy), 128'(1));
    wr(5'd9, 32'h5555);
    chk("busy_done", 128'(ifa.busy), 128'(0));
    chk("drop_final_edge", 128'(ifa.write_dropped), 128'(1));
    ri = {5'd0, 5'd0, 5'd7, 5'd9};
    #2 chk("dropped_entries_zero", 128'(ifa.read_data), 128'(0));
    step();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 299) == 0) begin
        reg_write = 1'b0;
        reset_n = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
      end
      reg_write = $urandom_range(0, 1) == 1;
      wi = 5'($urandom_range(0, 20));
      wd = $urandom;
      for (int p = 0; p < 4; p++)
        ri[p*5 +: 5] = ($urandom_range(0, 3) == 0) ? wi : 5'($urandom_range(0, 18));
      step();
    end
    reg_write = 1'b0;
    step();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
